// File: rtl/seg_dynamic_drv_pkg.sv
// Shared definitions for the multiplexed 7-segment display blocks:
// digit geometry, active-low segment codes, converter states and helpers.
package seg_dynamic_drv_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int BCD_W      = 4;
  localparam int BIN_W      = 20;
  localparam int BCD_TOT_W  = NUM_DIGITS * BCD_W;

  localparam logic [BIN_W-1:0] BIN_MAX = 20'd999_999;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_e;

  typedef struct packed {
    logic [BCD_TOT_W-1:0]  bcd;
    logic [NUM_DIGITS-1:0] point;
    logic                  sign;
  } disp_t;

  function automatic logic [6:0] seg_code(input logic [BCD_W-1:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = SEG_0;
      4'd1:    c = SEG_1;
      4'd2:    c = SEG_2;
      4'd3:    c = SEG_3;
      4'd4:    c = SEG_4;
      4'd5:    c = SEG_5;
      4'd6:    c = SEG_6;
      4'd7:    c = SEG_7;
      4'd8:    c = SEG_8;
      4'd9:    c = SEG_9;
      default: c = SEG_BLANK;
    endcase
    return c;
  endfunction

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_TOT_W-1:0] dabble_adjust(input logic [BCD_TOT_W-1:0] b);
    logic [BCD_TOT_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[i*BCD_W +: BCD_W] >= 4'd5) r[i*BCD_W +: BCD_W] = b[i*BCD_W +: BCD_W] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_dynamic_drv_bin2bcd_seq.sv
// Sequential 20-bit binary to 6-digit BCD converter (double-dabble, one bit per cycle).
module bin2bcd_seq
  import seg_dynamic_drv_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [BIN_W-1:0]     bin_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [BCD_TOT_W-1:0] bcd_o
);

  conv_state_e            state_q, state_d;
  logic [BIN_W-1:0]       bin_q, bin_d;
  logic [BCD_TOT_W-1:0]   bcd_q, bcd_d;
  logic [4:0]             iter_q, iter_d;
  logic [BCD_TOT_W-1:0]   adj;
  logic [BCD_TOT_W+BIN_W-1:0] sh;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CONV_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    adj     = dabble_adjust(bcd_q);
    sh      = {adj, bin_q} << 1;
    case (state_q)
      CONV_IDLE: begin
        if (start_i) begin
          bin_d   = (bin_i > BIN_MAX) ? BIN_MAX : bin_i;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = CONV_SHIFT;
        end
      end
      CONV_SHIFT: begin
        bcd_d  = sh[BCD_TOT_W+BIN_W-1:BIN_W];
        bin_d  = sh[BIN_W-1:0];
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'(BIN_W - 1)) state_d = CONV_DONE;
      end
      CONV_DONE: state_d = CONV_IDLE;
      default:   state_d = CONV_IDLE;
    endcase
  end

  assign busy_o = (state_q != CONV_IDLE);
  assign done_o = (state_q == CONV_DONE);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_dynamic_drv.sv
// Six-digit common-anode 7-segment scanner: BCD conversion, zero blanking,
// sign/point placement and frame-synchronous display update.
module seg_dynamic_drv
  import seg_dynamic_drv_pkg::*;
#(
  parameter int CNT_SCAN_MAX = 49_999
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [BIN_W-1:0]      data,
  input  logic [NUM_DIGITS-1:0] point,
  input  logic                  sign,
  input  logic                  seg_en,
  output logic [NUM_DIGITS-1:0] sel,
  output logic [7:0]            seg
);

  localparam int               CNT_W    = (CNT_SCAN_MAX > 0) ? $clog2(CNT_SCAN_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_SCAN_MAX);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  disp_t                 samp_q, samp_d;
  disp_t                 pend_q, pend_d;
  disp_t                 disp_q, disp_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]            seg_q, seg_d;

  logic                  conv_busy;
  logic                  conv_done;
  logic [BCD_TOT_W-1:0]  conv_bcd;

  logic [2:0]            msd, hp, top;
  logic [BCD_W-1:0]      digit;
  logic                  slot_end;

  bin2bcd_seq u_bin2bcd (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .start_i (1'b1),
    .bin_i   (data),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      samp_q <= '0;
      pend_q <= '0;
      disp_q <= '0;
      sel_q  <= '1;
      seg_q  <= '1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      samp_q <= samp_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      sel_q  <= sel_d;
      seg_q  <= seg_d;
    end
  end

  // Point/sign are captured on the same edge the converter takes its operand.
  always_comb begin
    samp_d = samp_q;
    pend_d = pend_q;
    if (!conv_busy) begin
      samp_d.point = point;
      samp_d.sign  = sign;
    end
    if (conv_done) begin
      pend_d.bcd   = conv_bcd;
      pend_d.point = samp_q.point;
      pend_d.sign  = samp_q.sign;
    end
  end

  // Display only follows pending at the frame wrap so a frame is never torn.
  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    disp_d   = disp_q;
    if (slot_end) begin
      if (idx_q == 3'(NUM_DIGITS - 1)) begin
        idx_d  = '0;
        disp_d = pend_q;
      end else begin
        idx_d  = idx_q + 3'd1;
      end
    end
  end

  always_comb begin
    msd = '0;
    hp  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (disp_q.bcd[i*BCD_W +: BCD_W] != '0) msd = 3'(i);
      if (disp_q.point[i])                    hp  = 3'(i);
    end
    top   = (msd > hp) ? msd : hp;
    digit = disp_q.bcd[{idx_q, 2'b00} +: BCD_W];

    sel_d = '1;
    seg_d = '1;
    if (seg_en) begin
      sel_d = ~(6'b000001 << idx_q);
      if (idx_q <= top)
        seg_d = {~disp_q.point[idx_q], seg_code(digit)};
      else if (disp_q.sign && (top < 3'(NUM_DIGITS - 1)) && (idx_q == top + 3'd1))
        seg_d = {1'b1, SEG_MINUS};
      else
        seg_d = {1'b1, SEG_BLANK};
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_dynamic_drv.sv
// Directed bench for seg_dynamic_drv with a 10-cycle digit slot.
module tb_seg_dynamic_drv;

  localparam int SCAN = 9;
  localparam int SLOT = SCAN + 1;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [19:0] data    = '0;
  logic [5:0]  point   = '0;
  logic        sign    = 1'b0;
  logic        seg_en  = 1'b1;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int n_checks = 0;
  int n_fail   = 0;

  seg_dynamic_drv #(.CNT_SCAN_MAX(SCAN)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .data    (data),
    .point   (point),
    .sign    (sign),
    .seg_en  (seg_en),
    .sel     (sel),
    .seg     (seg)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns on the first negedge of a new frame (slot 0 just selected).
  task automatic sync_frame();
    int k;
    k = 0;
    while (sel == 6'h3E && k < 200) begin @(negedge sys_clk); k++; end
    while (sel != 6'h3E && k < 400) begin @(negedge sys_clk); k++; end
    chk("frame_sync", {2'b00, sel}, 8'h3E);
  endtask

  // exp = {slot5, ..., slot0}
  task automatic check_frame(input string tag, input logic [47:0] exp);
    logic [5:0] es;
    for (int i = 0; i < 6; i++) begin
      es = ~(6'b000001 << i);
      chk($sformatf("%s_sel%0d", tag, i), {2'b00, sel}, {2'b00, es});
      chk($sformatf("%s_seg%0d", tag, i), seg, exp[8*i +: 8]);
      if (i < 5) repeat (SLOT) @(negedge sys_clk);
    end
  endtask

  initial begin
    logic [5:0] es;
    int k;

    // 1: reset and first frame of value 0
    repeat (3) @(negedge sys_clk);
    chk("rst_sel", {2'b00, sel}, 8'h3F);
    chk("rst_seg", seg, 8'hFF);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_frame("t1", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});

    // 2: full-width value with one decimal point
    data = 20'd123456; point = 6'b000010; sign = 1'b0;
    repeat (130) @(negedge sys_clk);
    sync_frame();
    check_frame("t2", {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h12, 8'h82});

    // 3: "-0.5" : point widens the field, minus sits one left of it
    data = 20'd5; point = 6'b000010; sign = 1'b1;
    repeat (130) @(negedge sys_clk);
    sync_frame();
    check_frame("t3", {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h40, 8'h92});

    // 4: clamped to 999999, no room for the minus
    data = 20'd1_000_000; point = 6'b000000; sign = 1'b1;
    repeat (130) @(negedge sys_clk);
    sync_frame();
    check_frame("t4", {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90});

    // 5: disable during slot 3, re-enable during slot 4
    k = 0;
    while (sel != 6'h37 && k < 100) begin @(negedge sys_clk); k++; end
    chk("t5_find_slot3", {2'b00, sel}, 8'h37);
    repeat (2) @(negedge sys_clk);
    seg_en = 1'b0;
    @(negedge sys_clk);
    chk("t5_off_sel", {2'b00, sel}, 8'h3F);
    chk("t5_off_seg", seg, 8'hFF);
    repeat (7) @(negedge sys_clk);
    chk("t5_dark_sel", {2'b00, sel}, 8'h3F);
    repeat (2) @(negedge sys_clk);
    seg_en = 1'b1;
    @(negedge sys_clk);
    chk("t5_on_sel", {2'b00, sel}, 8'h2F);
    chk("t5_on_seg", seg, 8'h90);

    // 6: change data right after slot 0; the frame must stay 1s until the wrap
    data = 20'd111111; point = 6'b000000; sign = 1'b0;
    repeat (130) @(negedge sys_clk);
    sync_frame();
    for (int i = 0; i < 12; i++) begin
      es = ~(6'b000001 << (i % 6));
      chk($sformatf("t6_sel%0d", i), {2'b00, sel}, {2'b00, es});
      chk($sformatf("t6_seg%0d", i), seg, (i < 6) ? 8'hF9 : 8'hA4);
      if (i == 0) data = 20'd222222;
      if (i < 11) repeat (SLOT) @(negedge sys_clk);
    end

    // Reset pulse while the converter is running
    repeat (3) @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    chk("t6_rst_sel", {2'b00, sel}, 8'h3F);
    chk("t6_rst_seg", seg, 8'hFF);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("t6_post_sel0", {2'b00, sel}, 8'h3E);
    chk("t6_post_seg0", seg, 8'hC0);
    repeat (SLOT) @(negedge sys_clk);
    chk("t6_post_sel1", {2'b00, sel}, 8'h3D);
    chk("t6_post_seg1", seg, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench did not complete");
  end

endmodule
